risc_exe: RTL
=============

Name: risc_exe

Overview:
- Execute stage of the 4-stage RISC pipeline (IF, DOF, EX, WB).
- Consumes the DOF pipeline register outputs and performs ALU, shift and iterative multiply operations.
- Resolves branches and drives the data-memory port.
- Returns the branch decision and the forwarded result Bus_D_prime back to DOF, and registers the result into the EX/WB stage.

Parameters:
- DATA_W, 32, datapath width.
- PC_W, 8, program counter width.
- MUL_CYCLES, 32, shift-add iterations per multiply (equals DATA_W).

Ports:
- CLK  in  1  clock; all state updates on the falling edge.
- reset  in  1  synchronous, active-high.
- PC_2  in  PC_W  PC of the instruction in EX.
- RW_reg, PS_reg, MW_reg  in  1 each  register write, branch polarity, memory write.
- DA_reg  in  5  destination register.
- MD_reg  in  2  result select: 00 F, 01 memory data, 10 set-less-than, 11 reserved (treated as F).
- BS_reg  in  2  branch select: 00 none, 01 conditional on Z, 10 jump, 11 relative.
- FS_reg  in  5  function select.
- SH_reg  in  5  shift amount.
- Bus_A_reg, Bus_B_reg  in  DATA_W  operands.
- mem_rdata  in  DATA_W  combinational data-memory read data.
- mem_addr, mem_wdata  out  DATA_W  equal to Bus_A_reg and Bus_B_reg.
- mem_we  out  1  MW_reg & ~stall.
- Bus_D_prime  out  DATA_W  forwarded result, selected by MD_reg.
- branch_predict  out  1  ~branch_taken; DOF squashes its instruction when this is 0.
- BrA  out  PC_W  branch target.
- stall  out  1  freezes IF/DOF while a multiply is in progress.
- RW_3  out  1  EX/WB register write enable.
- DA_3  out  5  EX/WB destination register.
- MD_3  out  2  EX/WB result select.
- F_3, Data_3  out  DATA_W  EX/WB result and memory data.

Behaviour:
- FS codes:
  - 00000 A; 00001 A+1; 00010 A+B; 00101 A+~B+1; 00110 A-1.
  - 01000 A&B; 01010 A|B; 01100 A^B; 01110 ~A; 10000 B.
  - 10100 A>>SH (logical); 11000 A<<SH; 11100 MUL (low DATA_W bits of A*B).
  - Any other code gives F = A.
- Flags, computed combinationally from the adder and F: Z = (F==0); N = F[DATA_W-1]; V = signed-add overflow.
- SLT result = {0…, N^V}.
- Branches:
  - branch_taken = (BS==01 & (PS ? ~Z : Z)) | BS==10 | BS==11.
  - BrA = Bus_A_reg[PC_W-1:0] when BS==10; otherwise PC_2 + Bus_B_reg[PC_W-1:0] with wrap-around.
  - BrA is don't-care when BS==00.
- Multiply FSM, states IDLE, BUSY, DONE:
  - IDLE with FS_reg==MUL: stall=1 combinationally. Next edge latches multiplicand, multiplier and acc=0, clears count, moves to BUSY.
  - BUSY: stall=1. Each edge adds the multiplicand to acc if the multiplier LSB is 1, shifts the multiplicand left and the multiplier right, and increments count. When count==MUL_CYCLES-1, moves to DONE.
  - DONE: stall=0; F = acc. Next edge writes the EX/WB register with RW_3=RW_reg and F_3=acc, then returns to IDLE.
  - Total EX occupancy is MUL_CYCLES+2 cycles.
  - While stall=1, the EX/WB register loads a bubble (RW_3=0), and branch_taken and mem_we are forced to 0.
- Non-multiply instructions have one-cycle latency: EX/WB register = {RW_reg, DA_reg, MD_reg, F, mem_rdata} at each edge.
- Bus_D_prime: mem_rdata when MD==01; SLT when MD==10; otherwise F (acc in DONE).
- Reset: all outputs and registers go to 0, FSM to IDLE, stall=0. This holds even in the middle of a multiply; the partial product is discarded.
- A MUL immediately following another MUL: after DONE, IDLE sees the new FS_reg==MUL and restarts. There are no back-to-back bubbles beyond the IDLE cycle.

Decomposition:
- Shared package risc_pkg holds:
  - FS opcode localparams.
  - MD and BS encodings.
  - FSM state encoding.
- Sub-module risc_mul_seq holds the shift-add multiplier and its FSM, with ports start, a, b, busy, done, product.
- ALU, shifter and branch logic stay in risc_exe.

Test Plan:
- ALU: A=5, B=3, FS=00101, MD=00, RW=1, DA=7 -> next edge F_3=2, RW_3=1, DA_3=7; Bus_D_prime=2 in the same cycle.
- SLT: A=-2, B=1, FS=00101, MD=10 -> Bus_D_prime=1. With A=1, B=-2 -> 0.
- Branch:
  - BS=01, PS=0, A=B=9, FS=00101 -> branch_predict=0, BrA=PC_2+B.
  - BS=10, A=0x40 -> BrA=0x40.
  - BS=00 -> branch_predict=1.
- Multiply: A=1234, B=5678, FS=11100 -> stall high for 33 cycles, then F_3=7006652 with RW_3=1. RW_3=0 throughout the stall.
- Shift: A=0x80000001, SH=4, FS=10100 -> F_3=0x08000000. Same operands with FS=11000 -> F_3=0x00000010.
- Reset at BUSY count 10 -> next edge: stall=0, state IDLE, RW_3=0. A following ADD completes normally.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared encodings for the RISC execute stage: function selects, result and
// branch selects, and the multiplier state encoding.
package risc_pkg;

   localparam logic [4:0] FS_A     = 5'b00000;
   localparam logic [4:0] FS_INC   = 5'b00001;
   localparam logic [4:0] FS_ADD   = 5'b00010;
   localparam logic [4:0] FS_SUB   = 5'b00101;
   localparam logic [4:0] FS_DEC   = 5'b00110;
   localparam logic [4:0] FS_AND   = 5'b01000;
   localparam logic [4:0] FS_OR    = 5'b01010;
   localparam logic [4:0] FS_XOR   = 5'b01100;
   localparam logic [4:0] FS_NOT   = 5'b01110;
   localparam logic [4:0] FS_B     = 5'b10000;
   localparam logic [4:0] FS_SRL   = 5'b10100;
   localparam logic [4:0] FS_SLL   = 5'b11000;
   localparam logic [4:0] FS_MUL   = 5'b11100;

   localparam logic [1:0] MD_F     = 2'b00;
   localparam logic [1:0] MD_MEM   = 2'b01;
   localparam logic [1:0] MD_SLT   = 2'b10;

   localparam logic [1:0] BS_NONE  = 2'b00;
   localparam logic [1:0] BS_COND  = 2'b01;
   localparam logic [1:0] BS_JUMP  = 2'b10;
   localparam logic [1:0] BS_REL   = 2'b11;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'b00,
      MUL_BUSY = 2'b01,
      MUL_DONE = 2'b10
   } mul_state_t;

endpackage

// File: rtl/risc_exe_if.sv
// DOF-to-EX operand bundle, data-memory port and the EX results returned to
// DOF and forwarded to WB.
interface risc_exe_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 8
);
   logic [PC_W-1:0]   PC_2;
   logic              RW_reg;
   logic              PS_reg;
   logic              MW_reg;
   logic [4:0]        DA_reg;
   logic [1:0]        MD_reg;
   logic [1:0]        BS_reg;
   logic [4:0]        FS_reg;
   logic [4:0]        SH_reg;
   logic [DATA_W-1:0] Bus_A_reg;
   logic [DATA_W-1:0] Bus_B_reg;
   logic [DATA_W-1:0] mem_rdata;

   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] Bus_D_prime;
   logic              branch_predict;
   logic [PC_W-1:0]   BrA;
   logic              stall;
   logic              RW_3;
   logic [4:0]        DA_3;
   logic [1:0]        MD_3;
   logic [DATA_W-1:0] F_3;
   logic [DATA_W-1:0] Data_3;

   modport master (
      output PC_2, RW_reg, PS_reg, MW_reg, DA_reg, MD_reg, BS_reg, FS_reg,
             SH_reg, Bus_A_reg, Bus_B_reg, mem_rdata,
      input  mem_addr, mem_wdata, mem_we, Bus_D_prime, branch_predict, BrA,
             stall, RW_3, DA_3, MD_3, F_3, Data_3
   );

   modport slave (
      input  PC_2, RW_reg, PS_reg, MW_reg, DA_reg, MD_reg, BS_reg, FS_reg,
             SH_reg, Bus_A_reg, Bus_B_reg, mem_rdata,
      output mem_addr, mem_wdata, mem_we, Bus_D_prime, branch_predict, BrA,
             stall, RW_3, DA_3, MD_3, F_3, Data_3
   );
endinterface

// File: rtl/risc_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per falling edge,
// product held in the accumulator during DONE.
//   state | meaning
//   IDLE  | waiting; start raises busy combinationally and loads operands
//   BUSY  | one shift-add step per edge, MUL_CYCLES steps in total
//   DONE  | product valid on 'product' for one cycle, busy low
module risc_mul_seq
   import risc_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int MUL_CYCLES = 32
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_CYCLES - 1);

   mul_state_t        state_q, state_d;
   logic [DATA_W-1:0] mcand_q;
   logic [DATA_W-1:0] mplier_q;
   logic [DATA_W-1:0] acc_q;
   logic [CNT_W-1:0]  count_q;

   always_ff @(negedge CLK) begin
      if (reset) state_q <= MUL_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         MUL_IDLE: begin
            if (start) begin
               busy    = 1'b1;
               state_d = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            busy = 1'b1;
            if (count_q == LAST_STEP) state_d = MUL_DONE;
         end
         MUL_DONE: begin
            done    = 1'b1;
            state_d = MUL_IDLE;
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   // Reset clears the accumulator too, so an aborted multiply leaves no residue.
   always_ff @(negedge CLK) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         count_q  <= '0;
      end else begin
         case (state_q)
            MUL_IDLE: begin
               if (start) begin
                  mcand_q  <= a;
                  mplier_q <= b;
                  acc_q    <= '0;
                  count_q  <= '0;
               end
            end
            MUL_BUSY: begin
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign product = acc_q;

endmodule

// File: rtl/risc_exe.sv
// Execute stage: ALU, shifter, flags, branch resolution, data-memory drive and
// the EX/WB pipeline register. Multiplies are delegated to risc_mul_seq.
module risc_exe
   import risc_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int PC_W       = 8,
   parameter int MUL_CYCLES = 32
) (
   input  logic       CLK,
   input  logic       reset,
   risc_exe_if.slave  bus
);

   logic [DATA_W-1:0] a, b;
   logic [DATA_W-1:0] add_b;
   logic              add_cin;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] f;
   logic              z_flag, n_flag, v_flag;
   logic [DATA_W-1:0] slt;
   logic              branch_taken;
   logic              mul_start, mul_busy, mul_done;
   logic [DATA_W-1:0] mul_product;
   logic              stall;

   assign a = bus.Bus_A_reg;
   assign b = bus.Bus_B_reg;

   assign mul_start = (bus.FS_reg == FS_MUL);

   risc_mul_seq #(
      .DATA_W     (DATA_W),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .CLK     (CLK),
      .reset   (reset),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   assign stall = mul_busy;

   // A single adder serves INC/ADD/SUB/DEC; other codes see A+0 so V stays 0.
   always_comb begin
      add_b   = '0;
      add_cin = 1'b0;
      case (bus.FS_reg)
         FS_INC: add_cin = 1'b1;
         FS_ADD: add_b   = b;
         FS_SUB: begin
            add_b   = ~b;
            add_cin = 1'b1;
         end
         FS_DEC: add_b   = '1;
         default: ;
      endcase
   end

   assign sum    = a + add_b + DATA_W'(add_cin);
   assign v_flag = (a[DATA_W-1] == add_b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

   always_comb begin
      f = a;
      case (bus.FS_reg)
         FS_A:   f = a;
         FS_INC, FS_ADD, FS_SUB, FS_DEC: f = sum;
         FS_AND: f = a & b;
         FS_OR:  f = a | b;
         FS_XOR: f = a ^ b;
         FS_NOT: f = ~a;
         FS_B:   f = b;
         FS_SRL: f = a >> bus.SH_reg;
         FS_SLL: f = a << bus.SH_reg;
         FS_MUL: f = mul_done ? mul_product : a;
         default: f = a;
      endcase
   end

   assign z_flag = (f == '0);
   assign n_flag = f[DATA_W-1];
   assign slt    = {{(DATA_W-1){1'b0}}, n_flag ^ v_flag};

   always_comb begin
      branch_taken = 1'b0;
      case (bus.BS_reg)
         BS_COND: branch_taken = bus.PS_reg ? ~z_flag : z_flag;
         BS_JUMP: branch_taken = 1'b1;
         BS_REL:  branch_taken = 1'b1;
         default: branch_taken = 1'b0;
      endcase
      if (stall) branch_taken = 1'b0;
   end

   assign bus.branch_predict = ~branch_taken;
   assign bus.BrA = (bus.BS_reg == BS_JUMP) ? a[PC_W-1:0] : bus.PC_2 + b[PC_W-1:0];

   always_comb begin
      case (bus.MD_reg)
         MD_MEM:  bus.Bus_D_prime = bus.mem_rdata;
         MD_SLT:  bus.Bus_D_prime = slt;
         default: bus.Bus_D_prime = f;
      endcase
   end

   assign bus.mem_addr  = a;
   assign bus.mem_wdata = b;
   assign bus.mem_we    = bus.MW_reg & ~stall;
   assign bus.stall     = stall;

   // A stalled cycle writes a bubble so WB never retires a half-done multiply.
   always_ff @(negedge CLK) begin
      if (reset || stall) begin
         bus.RW_3   <= 1'b0;
         bus.DA_3   <= '0;
         bus.MD_3   <= '0;
         bus.F_3    <= '0;
         bus.Data_3 <= '0;
      end else begin
         bus.RW_3   <= bus.RW_reg;
         bus.DA_3   <= bus.DA_reg;
         bus.MD_3   <= bus.MD_reg;
         bus.F_3    <= f;
         bus.Data_3 <= bus.mem_rdata;
      end
   end

endmodule
